id_ex_alu_issue: RTL and testbench

ID/EX pipeline stage that registers a decoded instruction and presents final operands and control to the execute-stage ALU, one instruction per cycle. It captures register-file operands, immediate and PC from decode, resolves MEM/WB forwarding onto the ALU operand inputs, and owns the valid/ready handshake between decode and execute. It also generates load-use hazard stalls and branch flushes for the execute slot.

---
 rtl/id_ex_alu_issue.sv | 173 +++++++++++++++++
 tb/tb_id_ex_alu_issue.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage: holds one decoded instruction, resolves MEM/WB
// forwarding onto the ALU operands, and owns the decode/execute handshake,
// load-use stall and branch flush for the execute slot.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module id_ex_alu_issue #(
  parameter int unsigned XLEN = `XLEN_64b,
  localparam int unsigned W = 1 << (XLEN + 4)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_id_valid,
  output logic         o_id_ready,
  input  logic [W-1:0] i_id_pc,
  input  logic [W-1:0] i_id_imm,
  input  logic [W-1:0] i_id_rs1_data,
  input  logic [W-1:0] i_id_rs2_data,
  input  logic [4:0]   i_id_rs1_addr,
  input  logic [4:0]   i_id_rs2_addr,
  input  logic [4:0]   i_id_rd_addr,
  input  logic         i_id_reg_write,
  input  logic [2:0]   i_id_alu_op,
  input  logic [1:0]   i_id_alu_shift,
  input  logic         i_id_src_a_sel,
  input  logic         i_id_src_b_sel,
  input  logic         i_mem_fwd_valid,
  input  logic         i_mem_fwd_pending,
  input  logic [4:0]   i_mem_fwd_rd,
  input  logic [W-1:0] i_mem_fwd_data,
  input  logic         i_wb_fwd_valid,
  input  logic [4:0]   i_wb_fwd_rd,
  input  logic [W-1:0] i_wb_fwd_data,
  input  logic         i_ex_ready,
  input  logic         i_flush,
  output logic         o_ex_valid,
  output logic [W-1:0] o_op_a,
  output logic [W-1:0] o_op_b,
  output logic [2:0]   o_alu_op,
  output logic [1:0]   o_alu_shift,
  output logic [W-1:0] o_store_data,
  output logic [4:0]   o_rd_addr,
  output logic         o_reg_write,
  output logic         o_hazard_stall
);

  logic         valid_q, valid_d;
  logic [W-1:0] pc_q, pc_d, imm_q, imm_d;
  logic [W-1:0] rs1_val_q, rs1_val_d, rs2_val_q, rs2_val_d;
  logic [4:0]   rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
  logic         reg_write_q, reg_write_d;
  logic [2:0]   alu_op_q, alu_op_d;
  logic [1:0]   alu_shift_q, alu_shift_d;
  logic         src_a_sel_q, src_a_sel_d, src_b_sel_q, src_b_sel_d;

  logic         mem_hit1, mem_hit2, wb_hit1, wb_hit2;
  logic [W-1:0] rs1_fwd, rs2_fwd;
  logic         stall, ex_valid, free, load;

  // Forwarding: x0 reads zero, MEM beats WB, otherwise the held value.
  always_comb begin
    mem_hit1 = (rs1_addr_q != '0) && i_mem_fwd_valid && (i_mem_fwd_rd == rs1_addr_q);
    mem_hit2 = (rs2_addr_q != '0) && i_mem_fwd_valid && (i_mem_fwd_rd == rs2_addr_q);
    wb_hit1  = (rs1_addr_q != '0) && i_wb_fwd_valid && (i_wb_fwd_rd == rs1_addr_q);
    wb_hit2  = (rs2_addr_q != '0) && i_wb_fwd_valid && (i_wb_fwd_rd == rs2_addr_q);
    rs1_fwd = rs1_val_q;
    if (rs1_addr_q == '0)  rs1_fwd = '0;
    else if (mem_hit1)     rs1_fwd = i_mem_fwd_data;
    else if (wb_hit1)      rs1_fwd = i_wb_fwd_data;
    rs2_fwd = rs2_val_q;
    if (rs2_addr_q == '0)  rs2_fwd = '0;
    else if (mem_hit2)     rs2_fwd = i_mem_fwd_data;
    else if (wb_hit2)      rs2_fwd = i_wb_fwd_data;
  end

  // Hazard, handshake and ALU-facing outputs.
  always_comb begin
    // rs2 always counts as used since store data needs it.
    stall    = valid_q && i_mem_fwd_pending &&
               ((!src_a_sel_q && mem_hit1) || mem_hit2);
    ex_valid = valid_q && !stall && !i_flush;
    free     = i_flush || (ex_valid && i_ex_ready);
    load     = i_id_valid && (!valid_q || free) && !i_flush;

    o_hazard_stall = stall;
    o_ex_valid     = ex_valid;
    o_id_ready     = !valid_q || free;
    o_op_a         = src_a_sel_q ? pc_q : rs1_fwd;
    o_op_b         = src_b_sel_q ? imm_q : rs2_fwd;
    o_store_data   = rs2_fwd;
    o_alu_op       = alu_op_q;
    o_alu_shift    = alu_shift_q;
    o_rd_addr      = rd_q;
    o_reg_write    = reg_write_q;
  end

  // Slot next state: load, free, or hold while absorbing WB retirements.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    imm_d       = imm_q;
    rs1_val_d   = rs1_val_q;
    rs2_val_d   = rs2_val_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    alu_op_d    = alu_op_q;
    alu_shift_d = alu_shift_q;
    src_a_sel_d = src_a_sel_q;
    src_b_sel_d = src_b_sel_q;
    if (load) begin
      valid_d     = 1'b1;
      pc_d        = i_id_pc;
      imm_d       = i_id_imm;
      rs1_val_d   = i_id_rs1_data;
      rs2_val_d   = i_id_rs2_data;
      rs1_addr_d  = i_id_rs1_addr;
      rs2_addr_d  = i_id_rs2_addr;
      rd_d        = i_id_rd_addr;
      reg_write_d = i_id_reg_write;
      alu_op_d    = i_id_alu_op;
      alu_shift_d = i_id_alu_shift;
      src_a_sel_d = i_id_src_a_sel;
      src_b_sel_d = i_id_src_b_sel;
    end else if (free) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      // A WB write retiring during a stall would otherwise be lost.
      if (wb_hit1) rs1_val_d = i_wb_fwd_data;
      if (wb_hit2) rs2_val_d = i_wb_fwd_data;
    end
  end

  // Held slot registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_val_q   <= '0;
      rs2_val_q   <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      alu_op_q    <= '0;
      alu_shift_q <= '0;
      src_a_sel_q <= 1'b0;
      src_b_sel_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      rs1_val_q   <= rs1_val_d;
      rs2_val_q   <= rs2_val_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      alu_op_q    <= alu_op_d;
      alu_shift_q <= alu_shift_d;
      src_a_sel_q <= src_a_sel_d;
      src_b_sel_q <= src_b_sel_d;
    end
  end

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Testbench for id_ex_alu_issue: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the held slot.

module tb_id_ex_alu_issue;
  localparam int unsigned W = 64;

  logic         i_clk, i_rst_n;
  logic         i_id_valid, o_id_ready;
  logic [W-1:0] i_id_pc, i_id_imm, i_id_rs1_data, i_id_rs2_data;
  logic [4:0]   i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr;
  logic         i_id_reg_write;
  logic [2:0]   i_id_alu_op;
  logic [1:0]   i_id_alu_shift;
  logic         i_id_src_a_sel, i_id_src_b_sel;
  logic         i_mem_fwd_valid, i_mem_fwd_pending;
  logic [4:0]   i_mem_fwd_rd;
  logic [W-1:0] i_mem_fwd_data;
  logic         i_wb_fwd_valid;
  logic [4:0]   i_wb_fwd_rd;
  logic [W-1:0] i_wb_fwd_data;
  logic         i_ex_ready, i_flush;
  logic         o_ex_valid;
  logic [W-1:0] o_op_a, o_op_b, o_store_data;
  logic [2:0]   o_alu_op;
  logic [1:0]   o_alu_shift;
  logic [4:0]   o_rd_addr;
  logic         o_reg_write, o_hazard_stall;

  id_ex_alu_issue #(.XLEN(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_valid(i_id_valid), .o_id_ready(o_id_ready),
    .i_id_pc(i_id_pc), .i_id_imm(i_id_imm),
    .i_id_rs1_data(i_id_rs1_data), .i_id_rs2_data(i_id_rs2_data),
    .i_id_rs1_addr(i_id_rs1_addr), .i_id_rs2_addr(i_id_rs2_addr),
    .i_id_rd_addr(i_id_rd_addr), .i_id_reg_write(i_id_reg_write),
    .i_id_alu_op(i_id_alu_op), .i_id_alu_shift(i_id_alu_shift),
    .i_id_src_a_sel(i_id_src_a_sel), .i_id_src_b_sel(i_id_src_b_sel),
    .i_mem_fwd_valid(i_mem_fwd_valid), .i_mem_fwd_pending(i_mem_fwd_pending),
    .i_mem_fwd_rd(i_mem_fwd_rd), .i_mem_fwd_data(i_mem_fwd_data),
    .i_wb_fwd_valid(i_wb_fwd_valid), .i_wb_fwd_rd(i_wb_fwd_rd),
    .i_wb_fwd_data(i_wb_fwd_data),
    .i_ex_ready(i_ex_ready), .i_flush(i_flush),
    .o_ex_valid(o_ex_valid), .o_op_a(o_op_a), .o_op_b(o_op_b),
    .o_alu_op(o_alu_op), .o_alu_shift(o_alu_shift),
    .o_store_data(o_store_data), .o_rd_addr(o_rd_addr),
    .o_reg_write(o_reg_write), .o_hazard_stall(o_hazard_stall)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the instruction sitting in the slot.
  typedef struct packed {
    logic         v;
    logic [W-1:0] pc, imm, r1v, r2v;
    logic [4:0]   r1, r2, rd;
    logic         rw;
    logic [2:0]   op;
    logic [1:0]   sh;
    logic         sa, sb;
  } slot_t;

  slot_t m;

  function automatic logic [W-1:0] src_value(input logic [4:0] a, input logic [W-1:0] held);
    if (a == 0) return '0;
    if (i_mem_fwd_valid && i_mem_fwd_rd == a) return i_mem_fwd_data;
    if (i_wb_fwd_valid && i_wb_fwd_rd == a) return i_wb_fwd_data;
    return held;
  endfunction

  function automatic logic waits_on_load(input logic [4:0] a);
    return a != 0 && i_mem_fwd_valid && i_mem_fwd_pending && i_mem_fwd_rd == a;
  endfunction

  function automatic logic m_stall();
    return m.v && ((!m.sa && waits_on_load(m.r1)) || waits_on_load(m.r2));
  endfunction

  function automatic logic m_exv();
    return m.v && !m_stall() && !i_flush;
  endfunction

  function automatic logic m_ready();
    return !m.v || i_flush || (m_exv() && i_ex_ready);
  endfunction

  function automatic slot_t m_next();
    slot_t n;
    n = m;
    if (i_id_valid && m_ready() && !i_flush) begin
      n.v = 1'b1; n.pc = i_id_pc; n.imm = i_id_imm;
      n.r1v = i_id_rs1_data; n.r2v = i_id_rs2_data;
      n.r1 = i_id_rs1_addr; n.r2 = i_id_rs2_addr; n.rd = i_id_rd_addr;
      n.rw = i_id_reg_write; n.op = i_id_alu_op; n.sh = i_id_alu_shift;
      n.sa = i_id_src_a_sel; n.sb = i_id_src_b_sel;
    end else if (i_flush || (m_exv() && i_ex_ready)) begin
      n.v = 1'b0;
    end else if (m.v && i_wb_fwd_valid) begin
      if (m.r1 != 0 && i_wb_fwd_rd == m.r1) n.r1v = i_wb_fwd_data;
      if (m.r2 != 0 && i_wb_fwd_rd == m.r2) n.r2v = i_wb_fwd_data;
    end
    return n;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) m <= '0;
    else          m <= m_next();
  end

  // Compare every cycle, mid-period, with inputs settled.
  always @(negedge i_clk) begin
    check("ex_valid",   {63'd0, o_ex_valid},     {63'd0, m_exv()});
    check("id_ready",   {63'd0, o_id_ready},     {63'd0, m_ready()});
    check("stall",      {63'd0, o_hazard_stall}, {63'd0, m_stall()});
    check("op_a",       o_op_a,       m.sa ? m.pc : src_value(m.r1, m.r1v));
    check("op_b",       o_op_b,       m.sb ? m.imm : src_value(m.r2, m.r2v));
    check("store_data", o_store_data, src_value(m.r2, m.r2v));
    check("ctl",        {50'd0, o_alu_op, o_alu_shift, o_rd_addr, o_reg_write},
                        {50'd0, m.op, m.sh, m.rd, m.rw});
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    i_id_valid = 0; i_id_pc = '0; i_id_imm = '0;
    i_id_rs1_data = '0; i_id_rs2_data = '0;
    i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_id_rd_addr = '0;
    i_id_reg_write = 0; i_id_alu_op = '0; i_id_alu_shift = '0;
    i_id_src_a_sel = 0; i_id_src_b_sel = 0;
    i_mem_fwd_valid = 0; i_mem_fwd_pending = 0; i_mem_fwd_rd = '0; i_mem_fwd_data = '0;
    i_wb_fwd_valid = 0; i_wb_fwd_rd = '0; i_wb_fwd_data = '0;
    i_ex_ready = 1; i_flush = 0;
  endtask

  task automatic set_id(input logic [4:0] r1, input logic [W-1:0] d1,
                        input logic [4:0] r2, input logic [W-1:0] d2,
                        input logic [4:0] rd);
    i_id_valid = 1; i_id_pc = {32'd0, $urandom}; i_id_imm = {$urandom, $urandom};
    i_id_rs1_addr = r1; i_id_rs1_data = d1;
    i_id_rs2_addr = r2; i_id_rs2_data = d2; i_id_rd_addr = rd;
    i_id_reg_write = 1; i_id_alu_op = '0; i_id_alu_shift = '0;
    i_id_src_a_sel = 0; i_id_src_b_sel = 0;
  endtask

  initial begin
    idle_inputs();
    i_rst_n = 0;
    #2;
    check("rst ex_valid", {63'd0, o_ex_valid}, 64'd0);
    check("rst id_ready", {63'd0, o_id_ready}, 64'd1);
    check("rst op_a", o_op_a, 64'd0);
    check("rst store", o_store_data, 64'd0);
    tick();
    i_rst_n = 1;

    // Back-to-back ADD x?, rs1 = 5, rs2 = 7.
    for (int i = 0; i < 4; i++) begin
      set_id(5'd1, 64'd5, 5'd2, 64'd7, 5'(10 + i));
      settle();
      if (i > 0) begin
        check("b2b ex_valid", {63'd0, o_ex_valid}, 64'd1);
        check("b2b op_a", o_op_a, 64'd5);
        check("b2b op_b", o_op_b, 64'd7);
      end
      check("b2b id_ready", {63'd0, o_id_ready}, 64'd1);
      tick();
    end
    idle_inputs();
    settle();
    check("b2b last ex_valid", {63'd0, o_ex_valid}, 64'd1);
    check("b2b last rd", {59'd0, o_rd_addr}, 64'd13);
    tick();
    check("b2b drained", {63'd0, o_ex_valid}, 64'd0);

    // MEM beats WB; x0 ignores forwarding.
    set_id(5'd3, 64'h55, 5'd0, 64'd0, 5'd1);
    tick();
    idle_inputs();
    i_mem_fwd_valid = 1; i_mem_fwd_rd = 5'd3; i_mem_fwd_data = 64'h11;
    i_wb_fwd_valid = 1; i_wb_fwd_rd = 5'd3; i_wb_fwd_data = 64'h22;
    settle();
    check("mem prio op_a", o_op_a, 64'h11);
    set_id(5'd0, 64'h77, 5'd0, 64'd0, 5'd1);
    i_mem_fwd_rd = 5'd0; i_wb_fwd_rd = 5'd0;
    tick();
    idle_inputs();
    i_mem_fwd_valid = 1; i_mem_fwd_rd = 5'd0; i_mem_fwd_data = 64'h11;
    settle();
    check("x0 op_a", o_op_a, 64'd0);
    tick();
    idle_inputs();
    tick();

    // Load-use on rs2 = x4.
    set_id(5'd0, 64'd0, 5'd4, 64'd1, 5'd8);
    tick();
    idle_inputs();
    i_mem_fwd_valid = 1; i_mem_fwd_rd = 5'd4; i_mem_fwd_pending = 1;
    for (int c = 0; c < 2; c++) begin
      settle();
      check("lu stall", {63'd0, o_hazard_stall}, 64'd1);
      check("lu id_ready", {63'd0, o_id_ready}, 64'd0);
      check("lu ex_valid", {63'd0, o_ex_valid}, 64'd0);
      tick();
    end
    i_mem_fwd_pending = 0; i_mem_fwd_data = 64'h99;
    settle();
    check("lu release ex_valid", {63'd0, o_ex_valid}, 64'd1);
    check("lu store_data", o_store_data, 64'h99);
    tick();
    idle_inputs();
    tick();

    // WB retirement captured while execute is stalled.
    set_id(5'd6, 64'd1, 5'd0, 64'd0, 5'd9);
    tick();
    idle_inputs();
    i_ex_ready = 0;
    i_wb_fwd_valid = 1; i_wb_fwd_rd = 5'd6; i_wb_fwd_data = 64'hABCD;
    tick();
    i_wb_fwd_valid = 0; i_wb_fwd_data = '0;
    tick();
    tick();
    i_ex_ready = 1;
    settle();
    check("capture op_a", o_op_a, 64'hABCD);
    check("capture ex_valid", {63'd0, o_ex_valid}, 64'd1);
    tick();

    // Flush with a simultaneous decode, then flush alone.
    set_id(5'd1, 64'h10, 5'd0, 64'd0, 5'd2);
    tick();
    set_id(5'd1, 64'h20, 5'd0, 64'd0, 5'd2);
    i_ex_ready = 0; i_flush = 1;
    settle();
    check("flush ex_valid", {63'd0, o_ex_valid}, 64'd0);
    tick();
    idle_inputs();
    settle();
    check("flush+load empty", {63'd0, o_ex_valid}, 64'd0);
    check("flush+load ready", {63'd0, o_id_ready}, 64'd1);
    set_id(5'd1, 64'h20, 5'd0, 64'd0, 5'd2);
    i_ex_ready = 0;
    tick();
    idle_inputs();
    i_flush = 1;
    tick();
    i_flush = 0;
    set_id(5'd1, 64'h30, 5'd0, 64'd0, 5'd2);
    settle();
    check("post flush empty", {63'd0, o_ex_valid}, 64'd0);
    tick();
    idle_inputs();
    settle();
    check("post flush op_a", o_op_a, 64'h30);
    check("post flush ex_valid", {63'd0, o_ex_valid}, 64'd1);
    tick();

    // Asynchronous reset while an instruction is held.
    set_id(5'd1, 64'h44, 5'd0, 64'd0, 5'd3);
    tick();
    idle_inputs();
    i_ex_ready = 0;
    #2;
    i_rst_n = 0;
    #1;
    check("async ex_valid", {63'd0, o_ex_valid}, 64'd0);
    check("async id_ready", {63'd0, o_id_ready}, 64'd1);
    tick();
    i_rst_n = 1;
    i_ex_ready = 1;
    set_id(5'd1, 64'd5, 5'd0, 64'd0, 5'd4);
    tick();
    idle_inputs();
    settle();
    check("after rst ex_valid", {63'd0, o_ex_valid}, 64'd1);
    check("after rst op_a", o_op_a, 64'd5);
    tick();

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      i_id_valid        = ($urandom % 4) != 0;
      i_id_pc           = {$urandom, $urandom};
      i_id_imm          = {$urandom, $urandom};
      i_id_rs1_data     = {$urandom, $urandom};
      i_id_rs2_data     = {$urandom, $urandom};
      i_id_rs1_addr     = 5'($urandom % 8);
      i_id_rs2_addr     = 5'($urandom % 8);
      i_id_rd_addr      = 5'($urandom);
      i_id_reg_write    = 1'($urandom);
      i_id_alu_op       = 3'($urandom);
      i_id_alu_shift    = 2'($urandom);
      i_id_src_a_sel    = 1'($urandom);
      i_id_src_b_sel    = 1'($urandom);
      i_mem_fwd_valid   = 1'($urandom);
      i_mem_fwd_pending = ($urandom % 3) == 0;
      i_mem_fwd_rd      = 5'($urandom % 8);
      i_mem_fwd_data    = {$urandom, $urandom};
      i_wb_fwd_valid    = 1'($urandom);
      i_wb_fwd_rd       = 5'($urandom % 8);
      i_wb_fwd_data     = {$urandom, $urandom};
      i_ex_ready        = ($urandom % 4) != 0;
      i_flush           = ($urandom % 10) == 0;
      tick();
    end
    idle_inputs();
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
